dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline
// memory stage (port m) and a debug/loader port (port d). Each access is
// registered, strobed onto the memory for one cycle, waits a fixed read
// latency when it is a load, and finishes with a one-cycle ack to the winner.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous requests
//                   undefined -> fixed priority, m beats d
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    // pipeline port
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_ack,
    // debug/loader port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Port 0 is the pipeline, port 1 is the debug port.
    localparam int NPORT = 2;
    // Holds RD_LAT-1, at most 3.
    localparam int CNT_W = 2;

    // Read latencies beyond the counter range are rejected at elaboration.
    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("dmem_arbiter: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                port_reg, port_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                grant_id;
    logic                capture;

    logic [NPORT-1:0]    req_vec;
    logic [NPORT-1:0]    we_vec;
    logic [ADDR_W-1:0]   addr_vec  [NPORT];
    logic [DATA_W-1:0]   wdata_vec [NPORT];
    logic [DATA_W-1:0]   rdata_vec [NPORT];
    logic [NPORT-1:0]    ack_vec;

    assign req_vec      = {d_req, m_req};
    assign we_vec       = {d_we, m_we};
    assign addr_vec[0]  = m_addr;
    assign addr_vec[1]  = d_addr;
    assign wdata_vec[0] = m_wdata;
    assign wdata_vec[1] = d_wdata;

`ifdef DMEM_ARB_RR_EN
    // 1 = the debug port won the most recent grant.
    logic last_grant_reg, last_grant_next;

    // Round-robin: on a tie, serve the port that did not win last time.
    always_comb begin
        grant_id = 1'b0;
        if (req_vec[1] && (!req_vec[0] || !last_grant_reg)) begin
            grant_id = 1'b1;
        end
    end

    // Last-grant flag; reset to d so the pipeline wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    // Fixed priority: the pipeline always beats the debug port.
    always_comb begin
        grant_id = 1'b0;
        if (req_vec[1] && !req_vec[0]) begin
            grant_id = 1'b1;
        end
    end
`endif

    // State and latched command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            port_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            port_reg  <= port_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: grant in IDLE, strobe in ISSUE, count in WAIT, ack in ACK.
    always_comb begin
        state_next = state_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        port_next  = port_reg;
        cnt_next   = cnt_reg;
`ifdef DMEM_ARB_RR_EN
        last_grant_next = last_grant_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    we_next    = we_vec[grant_id];
                    addr_next  = addr_vec[grant_id];
                    wdata_next = wdata_vec[grant_id];
                    port_next  = grant_id;
`ifdef DMEM_ARB_RR_EN
                    last_grant_next = grant_id;
`endif
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = ACK;
                end else begin
                    cnt_next   = CNT_W'(RD_LAT - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    state_next = ACK;
                end
            end
            ACK: begin
                // Requests are not looked at here, so a held req is not regranted.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data is taken from the memory in the last WAIT cycle.
    assign capture = (state_reg == WAIT) && (cnt_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            // Per-port read data, held until the next load completes on this port.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (capture && (int'(port_reg) == gi)) begin
                    rdata_reg <= mem_rdata;
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign ack_vec[gi]   = (state_reg == ACK) && (int'(port_reg) == gi);
        end
    endgenerate

    assign m_rdata   = rdata_vec[0];
    assign d_rdata   = rdata_vec[1];
    assign m_ack     = ack_vec[0];
    assign d_ack     = ack_vec[1];

    assign mem_en    = (state_reg == ISSUE);
    assign mem_we    = (state_reg == ISSUE) && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule
